issue_scoreboard: RTL and testbench



---
 rtl/issue_scoreboard_pkg.sv | 28 ++
 rtl/issue_scoreboard_sb_counter.sv | 43 ++++
 rtl/issue_scoreboard.sv | 142 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared configuration for the issue scoreboard: register-file geometry,
// counter width, controller state encoding and the held-bundle layout.
package issue_scoreboard_pkg;

   localparam int REGNO     = 8;
   localparam int REGNO_LOG = 3;
   localparam int CNT_W     = 2;
   localparam int PAYLOAD_W = 32;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_HOLD  = 2'd1,
      SB_JWAIT = 2'd2
   } sb_state_e;

   typedef struct packed {
      logic [REGNO-1:0]     rf_ie;
      logic                 flags_ie;
      logic                 carry_en;
      logic                 pc_ie;
      logic [REGNO_LOG-1:0] l_sel;
      logic [REGNO_LOG-1:0] r_sel;
      logic                 r_bus_imm;
      logic                 l_used;
      logic [PAYLOAD_W-1:0] payload;
   } sb_bundle_t;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Outstanding-write counter for one register (or the flags): counts issued
// writes up and retired writes down, saturating at both ends.
module sb_counter
   import issue_scoreboard_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_at_max,
   output logic o_nonzero
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: simultaneous inc and dec cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && !i_dec) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + W'(1);
         else                  cnt_d = cnt_q;
      end else if (i_dec && !i_inc) begin
         if (cnt_q != '0) cnt_d = cnt_q - W'(1);
         else             cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign o_at_max  = (cnt_q == CNT_MAX);
   assign o_nonzero = |cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller between decode and execute: holds one bundle, tracks
// outstanding register/flag writes and releases the bundle only when hazard-free.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_submit,
   output logic                 o_ready,
   input  logic [REGNO_LOG-1:0] i_l_reg_sel,
   input  logic [REGNO_LOG-1:0] i_r_reg_sel,
   input  logic                 i_r_bus_imm,
   input  logic                 i_l_used,
   input  logic                 i_alu_carry_en,
   input  logic                 i_alu_flags_ie,
   input  logic [REGNO-1:0]     i_rf_ie,
   input  logic                 i_pc_ie,
   input  logic [PAYLOAD_W-1:0] i_payload,
   input  logic                 i_next_ready,
   output logic                 o_submit,
   output logic [REGNO-1:0]     o_rf_ie,
   output logic                 o_alu_flags_ie,
   output logic                 o_alu_carry_en,
   output logic                 o_pc_ie,
   output logic [REGNO_LOG-1:0] o_l_reg_sel,
   output logic [REGNO_LOG-1:0] o_r_reg_sel,
   output logic                 o_r_bus_imm,
   output logic [PAYLOAD_W-1:0] o_payload,
   input  logic [REGNO-1:0]     i_wb_rf_ie,
   input  logic                 i_wb_flags,
   input  logic                 i_pc_done,
   input  logic                 i_flush,
   output logic [REGNO-1:0]     o_busy
);

   sb_state_e        state_q, state_d;
   sb_bundle_t       held_q, held_d, out_q, out_d, in_bundle_s;
   logic             submit_q, submit_d;
   logic [REGNO-1:0] busy_s, at_max_s;
   logic             flags_busy_s, flags_at_max_s;
   logic             hazard_s, issue_s, ready_s, accept_s;

   assign in_bundle_s = '{rf_ie:     i_rf_ie,
                          flags_ie:  i_alu_flags_ie,
                          carry_en:  i_alu_carry_en,
                          pc_ie:     i_pc_ie,
                          l_sel:     i_l_reg_sel,
                          r_sel:     i_r_reg_sel,
                          r_bus_imm: i_r_bus_imm,
                          l_used:    i_l_used,
                          payload:   i_payload};

   // A jump waits until every register and flag write has retired.
   assign hazard_s = (held_q.l_used & busy_s[held_q.l_sel])
                   | (~held_q.r_bus_imm & busy_s[held_q.r_sel])
                   | (held_q.carry_en & flags_busy_s)
                   | (|(held_q.rf_ie & at_max_s))
                   | (held_q.flags_ie & flags_at_max_s)
                   | (held_q.pc_ie & ((|busy_s) | flags_busy_s));

   assign issue_s  = (state_q == SB_HOLD) & ~hazard_s & i_next_ready & ~i_flush;
   assign ready_s  = ~i_rst & ((state_q == SB_EMPTY) | issue_s) & ~(issue_s & held_q.pc_ie);
   assign accept_s = i_submit & ready_s & ~i_flush;

   // Next-state and held/issued bundle selection.
   always_comb begin
      state_d  = state_q;
      held_d   = held_q;
      out_d    = out_q;
      submit_d = issue_s;
      if (accept_s) held_d = in_bundle_s;
      else          held_d = held_q;
      if (issue_s) out_d = held_q;
      else         out_d = out_q;
      case (state_q)
         SB_EMPTY: begin
            if (accept_s) state_d = SB_HOLD;
            else          state_d = SB_EMPTY;
         end
         SB_HOLD: begin
            if (i_flush)                state_d = SB_EMPTY;
            else if (!issue_s)          state_d = SB_HOLD;
            else if (held_q.pc_ie)      state_d = SB_JWAIT;
            else if (accept_s)          state_d = SB_HOLD;
            else                        state_d = SB_EMPTY;
         end
         SB_JWAIT: begin
            if (i_pc_done) state_d = SB_EMPTY;
            else           state_d = SB_JWAIT;
         end
         default: state_d = SB_EMPTY;
      endcase
   end

   // State, held bundle and issue output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= SB_EMPTY;
         held_q   <= '0;
         out_q    <= '0;
         submit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         held_q   <= held_d;
         out_q    <= out_d;
         submit_q <= submit_d;
      end
   end

   for (genvar g = 0; g < REGNO; g++) begin : g_reg_cnt
      sb_counter #(.W(CNT_W)) u_cnt (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_inc     (issue_s & held_q.rf_ie[g]),
         .i_dec     (i_wb_rf_ie[g]),
         .o_at_max  (at_max_s[g]),
         .o_nonzero (busy_s[g])
      );
   end

   sb_counter #(.W(CNT_W)) u_flags_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_inc     (issue_s & held_q.flags_ie),
      .i_dec     (i_wb_flags),
      .o_at_max  (flags_at_max_s),
      .o_nonzero (flags_busy_s)
   );

   assign o_ready        = ready_s;
   assign o_submit       = submit_q;
   assign o_rf_ie        = out_q.rf_ie;
   assign o_alu_flags_ie = out_q.flags_ie;
   assign o_alu_carry_en = out_q.carry_en;
   assign o_pc_ie        = out_q.pc_ie;
   assign o_l_reg_sel    = out_q.l_sel;
   assign o_r_reg_sel    = out_q.r_sel;
   assign o_r_bus_imm    = out_q.r_bus_imm;
   assign o_payload      = out_q.payload;
   assign o_busy         = busy_s;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed-vector bench for issue_scoreboard: a table of per-cycle inputs with
// hand-computed ready/submit/busy expectations, plus reset sequences.
module tb_issue_scoreboard;

   typedef struct packed {
      logic [2:0] l;
      logic [2:0] r;
      logic       imm;
      logic       lu;
      logic [7:0] rf;
      logic       fie;
      logic       cen;
      logic       pc;
   } ins_t;

   typedef struct {
      logic       sub;
      ins_t       ins;
      logic       nr;
      logic [7:0] wb;
      logic       wbf;
      logic       fl;
      logic       pcd;
      logic       e_rdy;
      logic       e_sub;
      logic [7:0] e_rf;
      logic [7:0] e_busy;
   } vec_t;

   logic        clk = 1'b0;
   logic        i_rst, i_submit, i_r_bus_imm, i_l_used, i_alu_carry_en, i_alu_flags_ie;
   logic        i_pc_ie, i_next_ready, i_wb_flags, i_pc_done, i_flush;
   logic [2:0]  i_l_reg_sel, i_r_reg_sel;
   logic [7:0]  i_rf_ie, i_wb_rf_ie;
   logic [31:0] i_payload;
   logic        o_ready, o_submit, o_alu_flags_ie, o_alu_carry_en, o_pc_ie, o_r_bus_imm;
   logic [2:0]  o_l_reg_sel, o_r_reg_sel;
   logic [7:0]  o_rf_ie, o_busy;
   logic [31:0] o_payload;

   int   n_total = 0;
   int   n_pass  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   issue_scoreboard dut (
      .i_clk(clk), .i_rst(i_rst), .i_submit(i_submit), .o_ready(o_ready),
      .i_l_reg_sel(i_l_reg_sel), .i_r_reg_sel(i_r_reg_sel), .i_r_bus_imm(i_r_bus_imm),
      .i_l_used(i_l_used), .i_alu_carry_en(i_alu_carry_en), .i_alu_flags_ie(i_alu_flags_ie),
      .i_rf_ie(i_rf_ie), .i_pc_ie(i_pc_ie), .i_payload(i_payload), .i_next_ready(i_next_ready),
      .o_submit(o_submit), .o_rf_ie(o_rf_ie), .o_alu_flags_ie(o_alu_flags_ie),
      .o_alu_carry_en(o_alu_carry_en), .o_pc_ie(o_pc_ie), .o_l_reg_sel(o_l_reg_sel),
      .o_r_reg_sel(o_r_reg_sel), .o_r_bus_imm(o_r_bus_imm), .o_payload(o_payload),
      .i_wb_rf_ie(i_wb_rf_ie), .i_wb_flags(i_wb_flags), .i_pc_done(i_pc_done),
      .i_flush(i_flush), .o_busy(o_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic ins_t mk_ins(input logic [2:0] l, input logic [2:0] r, input logic imm,
                                   input logic lu, input logic [7:0] rf, input logic fie,
                                   input logic cen, input logic pc);
      ins_t t;
      t.l = l; t.r = r; t.imm = imm; t.lu = lu; t.rf = rf; t.fie = fie; t.cen = cen; t.pc = pc;
      return t;
   endfunction

   task automatic add(input logic sub, input ins_t ins, input logic nr, input logic [7:0] wb,
                      input logic wbf, input logic fl, input logic pcd, input logic e_rdy,
                      input logic e_sub, input logic [7:0] e_rf, input logic [7:0] e_busy);
      vec_t v;
      v.sub = sub; v.ins = ins; v.nr = nr; v.wb = wb; v.wbf = wbf; v.fl = fl; v.pcd = pcd;
      v.e_rdy = e_rdy; v.e_sub = e_sub; v.e_rf = e_rf; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      i_submit = v.sub; i_l_reg_sel = v.ins.l; i_r_reg_sel = v.ins.r; i_r_bus_imm = v.ins.imm;
      i_l_used = v.ins.lu; i_rf_ie = v.ins.rf; i_alu_flags_ie = v.ins.fie;
      i_alu_carry_en = v.ins.cen; i_pc_ie = v.ins.pc; i_next_ready = v.nr;
      i_wb_rf_ie = v.wb; i_wb_flags = v.wbf; i_flush = v.fl; i_pc_done = v.pcd;
   endtask

   initial begin
      ins_t none_i, add1, mov4, add5, w2, w3, jmp, fw, fr, w6;
      vec_t idle;
      none_i = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      add1   = mk_ins(3'd2, 3'd3, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      mov4   = mk_ins(3'd1, 3'd0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      add5   = mk_ins(3'd2, 3'd3, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      w2     = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
      w3     = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
      jmp    = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      fw     = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      fr     = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      w6     = mk_ins(3'd0, 3'd0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);

      // RAW on r1: MOV held until r1 retires
      add(1'b1, add1,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, mov4,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h10);
      add(1'b0, none_i, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      // independent back-to-back
      add(1'b1, add1,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, add5,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h22);
      add(1'b0, none_i, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      // r2 counter saturation: 4th write stalls, then drain proves count 3
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'h04);
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'h04);
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'h04);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04);
      add(1'b0, none_i, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'h04);
      add(1'b0, none_i, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04);
      add(1'b0, none_i, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04);
      add(1'b0, none_i, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      // same-cycle issue and writeback of r3
      add(1'b1, w3,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, w3,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 8'h08);
      add(1'b0, none_i, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 8'h08);
      add(1'b0, none_i, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      // jump waits for r1, then blocks decode until pc_done
      add(1'b1, add1,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, jmp,    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      // flush of a hazarded bundle; flush in EMPTY blocks capture
      add(1'b1, add1,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, mov4,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02);
      add(1'b0, none_i, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, w2,     1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      // flag RAW
      add(1'b1, fw,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, fr,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      // execute back-pressure
      add(1'b1, w6,     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      add(1'b0, none_i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h40);
      add(1'b0, none_i, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

      idle = vecs[vecs.size()-1];
      idle.wb = 8'h00;
      drive(idle);
      i_payload = 32'h0;

      // power-on reset
      i_rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst_submit", {31'd0, o_submit}, 32'd0);
      chk("rst_busy", {24'd0, o_busy}, 32'd0);
      chk("rst_payload", o_payload, 32'd0);
      i_rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), {31'd0, o_ready}, {31'd0, vecs[i].e_rdy});
         @(posedge clk); #1;
         chk($sformatf("v%0d_submit", i), {31'd0, o_submit}, {31'd0, vecs[i].e_sub});
         chk($sformatf("v%0d_busy", i), {24'd0, o_busy}, {24'd0, vecs[i].e_busy});
         if (vecs[i].e_sub) chk($sformatf("v%0d_rf_ie", i), {24'd0, o_rf_ie}, {24'd0, vecs[i].e_rf});
      end

      // reset while a hazarded bundle is held
      drive(idle);
      i_submit = 1'b1; i_l_reg_sel = add1.l; i_r_reg_sel = add1.r; i_r_bus_imm = add1.imm;
      i_l_used = add1.lu; i_rf_ie = add1.rf; i_payload = 32'hDEADBEEF;
      @(posedge clk); #1;
      i_l_reg_sel = mov4.l; i_r_bus_imm = mov4.imm; i_l_used = mov4.lu; i_rf_ie = mov4.rf;
      i_payload = 32'h12345678;
      @(posedge clk); #1;
      chk("mid_payload", o_payload, 32'hDEADBEEF);
      chk("mid_busy", {24'd0, o_busy}, 32'h02);
      i_submit = 1'b0;
      i_rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_submit", {31'd0, o_submit}, 32'd0);
      chk("mid_rst_busy", {24'd0, o_busy}, 32'd0);
      chk("mid_rst_rf_ie", {24'd0, o_rf_ie}, 32'd0);
      chk("mid_rst_payload", o_payload, 32'd0);
      i_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk); #1;
      chk("post_rst_submit", {31'd0, o_submit}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
